// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 scan-code controller.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  localparam int unsigned PS2_BYTE_W = 8;
  localparam int unsigned PS2_GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    CLASSIFY = 2'd2,
    GAP      = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_scan_ctrl_if.sv
// Ready/pop handshake between the PS/2 receiver FIFO (master) and the scan controller (slave).
interface ps2_scan_ctrl_if;
  import ps2_pkg::*;

  logic                  rx_ready;
  logic [PS2_BYTE_W-1:0] rx_data;
  logic                  rx_pop;

  modport master (output rx_ready, output rx_data, input rx_pop);
  modport slave  (input rx_ready, input rx_data, output rx_pop);

endinterface

// File: rtl/ps2_prefix_timer.sv
// Lone-prefix timeout: expire pulses once TIMEOUT_CYCLES pass after start without stop/restart.
module ps2_prefix_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (start) begin
        cnt    <= '0;
        active <= 1'b1;
      end else if (stop) begin
        active <= 1'b0;
      end else if (active) begin
        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          active <= 1'b0;
          expire <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Pops PS/2 scan bytes, tracks E0/F0 prefixes and emits make/break/repeat events.
// Optional lone-prefix timeout is enabled with `define PS2_PREFIX_TIMEOUT_EN.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
`ifdef PS2_PREFIX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_scan_ctrl_if.slave        rx,
  output logic [PS2_BYTE_W-1:0] key_code,
  output logic                  key_ext,
  output logic                  key_make,
  output logic                  key_break,
  output logic                  key_repeat,
  output logic                  key_held,
  output logic                  disp_on,
  output logic [7:0]            press_count,
  output logic                  proto_err
);

  ps2_state_e            state;
  logic [PS2_BYTE_W-1:0] byte_r;
  logic                  ext_p;
  logic                  brk_p;
  logic [PS2_GAP_W-1:0]  gap_cnt;
  logic                  is_prefix;
  logic                  same_key;
  logic                  tmo_expire;

  assign is_prefix = (byte_r == PS2_EXT) || (byte_r == PS2_BRK);
  assign same_key  = key_held && (byte_r == key_code) && (ext_p == key_ext);

`ifdef PS2_PREFIX_TIMEOUT_EN
  logic cls_active;
  assign cls_active = (state == CLASSIFY);

  ps2_prefix_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_prefix_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (cls_active && is_prefix),
    .stop   (cls_active && !is_prefix),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_r      <= '0;
      ext_p       <= 1'b0;
      brk_p       <= 1'b0;
      gap_cnt     <= '0;
      rx.rx_pop   <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_make    <= 1'b0;
      key_break   <= 1'b0;
      key_repeat  <= 1'b0;
      key_held    <= 1'b0;
      disp_on     <= 1'b0;
      press_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      rx.rx_pop  <= 1'b0;
      key_make   <= 1'b0;
      key_break  <= 1'b0;
      key_repeat <= 1'b0;

      // A classified byte takes precedence over a coincident timeout
      if (tmo_expire && (state != CLASSIFY)) begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx.rx_ready) begin
            rx.rx_pop <= 1'b1;
            state     <= FETCH;
          end
        end

        FETCH: begin
          byte_r <= rx.rx_data;
          state  <= CLASSIFY;
        end

        CLASSIFY: begin
          state   <= GAP;
          gap_cnt <= '0;
          if (byte_r == PS2_EXT) begin
            ext_p <= 1'b1;
          end else if (byte_r == PS2_BRK) begin
            brk_p <= 1'b1;
          end else if ((byte_r == PS2_ERR0) || (byte_r == PS2_ERR1)) begin
            proto_err <= 1'b1;
            ext_p     <= 1'b0;
            brk_p     <= 1'b0;
          end else begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
            if (brk_p) begin
              // Only a release of the held key is reported
              if (same_key) begin
                key_break <= 1'b1;
                key_held  <= 1'b0;
                disp_on   <= 1'b0;
              end
            end else if (same_key) begin
              key_repeat <= 1'b1;
            end else begin
              key_code    <= byte_r;
              key_ext     <= ext_p;
              key_make    <= 1'b1;
              key_held    <= 1'b1;
              disp_on     <= 1'b1;
              press_count <= press_count + 8'd1;
            end
          end
        end

        GAP: begin
          if (gap_cnt == PS2_GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + PS2_GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a FIFO model feeds bytes, a reference model predicts events.
module tb_ps2_scan_ctrl;
  import ps2_pkg::*;

  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 50;

  typedef struct packed {
    logic [1:0] kind;   // 1 make, 2 break, 3 repeat
    logic [7:0] code;
    logic       ext;
    logic [7:0] cnt;
    logic       held;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code, press_count;
  logic       key_ext, key_make, key_break, key_repeat, key_held, disp_on, proto_err;

  ps2_scan_ctrl_if rx_if ();

`ifdef PS2_PREFIX_TIMEOUT_EN
  ps2_scan_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
`else
  ps2_scan_ctrl #(.GAP_CYCLES(GAP)) dut (
`endif
    .clk(clk), .rst(rst), .rx(rx_if),
    .key_code(key_code), .key_ext(key_ext), .key_make(key_make),
    .key_break(key_break), .key_repeat(key_repeat), .key_held(key_held),
    .disp_on(disp_on), .press_count(press_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] fifo[$];
  ev_t        exp_q[$];
  bit         pend = 0;
  int         n_pops = 0;
  int         n_sent = 0;
  int         cyc = 0;
  int         last_pop = -1;
  bit         gap_en = 0;

  // reference model state
  logic       m_ext = 0, m_brk = 0, m_held = 0, m_kext = 0;
  logic [7:0] m_code = 0, m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_held = 0; m_kext = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit  same;
    ev_t e;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
    else begin
      same = m_held && (b == m_code) && (m_ext == m_kext);
      if (m_brk) begin
        if (same) begin
          m_held = 0;
          e = '{kind: 2'd2, code: m_code, ext: m_kext, cnt: m_cnt, held: 1'b0};
          exp_q.push_back(e);
        end
      end else if (same) begin
        e = '{kind: 2'd3, code: m_code, ext: m_kext, cnt: m_cnt, held: 1'b1};
        exp_q.push_back(e);
      end else begin
        m_code = b; m_kext = m_ext; m_cnt = m_cnt + 8'd1; m_held = 1;
        e = '{kind: 2'd1, code: m_code, ext: m_kext, cnt: m_cnt, held: 1'b1};
        exp_q.push_back(e);
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(b);
    n_sent++;
  endtask

  // FIFO model and event monitor, evaluated on every falling edge
  task automatic mon_step();
    ev_t e;
    logic [1:0] k;
    cyc++;
    if (!rst) begin
      if (pend) begin
        if (fifo.size() > 0) void'(fifo.pop_front());
        pend = 0;
      end
      if (rx_if.rx_pop) begin
        pend = 1;
        n_pops++;
        if (gap_en && last_pop >= 0) chk("pop_gap", 32'(cyc - last_pop), GAP + 3);
        last_pop = cyc;
      end
      if (key_make || key_break || key_repeat) begin
        chk("excl", 32'(int'(key_make) + int'(key_break) + int'(key_repeat)), 1);
        k = key_make ? 2'd1 : (key_break ? 2'd2 : 2'd3);
        if (exp_q.size() == 0) chk("unexp_evt", {30'd0, k}, 0);
        else begin
          e = exp_q.pop_front();
          chk("evt_kind", {30'd0, k}, {30'd0, e.kind});
          chk("evt_code", {24'd0, key_code}, {24'd0, e.code});
          chk("evt_ext", {31'd0, key_ext}, {31'd0, e.ext});
          chk("evt_cnt", {24'd0, press_count}, {24'd0, e.cnt});
          chk("evt_held", {31'd0, key_held}, {31'd0, e.held});
          chk("evt_disp", {31'd0, disp_on}, {31'd0, e.held});
        end
      end
    end else begin
      pend = 0;
    end
    rx_if.rx_ready = (fifo.size() > 0);
    rx_if.rx_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  function automatic logic [31:0] all_out();
    return {8'd0, key_code, key_ext, key_make, key_break, key_repeat, key_held,
            disp_on, press_count, proto_err, rx_if.rx_pop};
  endfunction

  task automatic clear_all();
    fifo.delete(); exp_q.delete(); model_clear();
    n_sent = 0; n_pops = 0; last_pop = -1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_all();
    repeat (2) @(negedge clk);
    chk("rst_out", all_out(), 0);
    rst = 0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((fifo.size() != 0 || pend) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) begin
      chk({tag, "_timeout"}, 1, 0);
      fifo.delete();
    end
    repeat (GAP + 6) @(negedge clk);
    chk({tag, "_pops"}, 32'(n_pops), 32'(n_sent));
    chk({tag, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int k;
    rx_if.rx_ready = 0;
    rx_if.rx_data  = 0;
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    do_reset();

    // make then break of a plain key
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain("mk_brk");
    chk("mk_brk_held", {31'd0, key_held}, 0);
    chk("mk_brk_cnt", {24'd0, press_count}, 1);

    // reset asserted mid-GAP after a lone E0
    send(8'hE0);
    k = 0;
    while (n_pops < n_sent && k < 50) begin @(negedge clk); k++; end
    chk("e0_pop_seen", 32'(n_pops), 32'(n_sent));
    repeat (2) @(negedge clk);
    rst = 1;
    clear_all();
    #1 chk("rst_async", all_out(), 0);
    @(posedge clk);
    #1 chk("rst_edge", all_out(), 0);
    @(negedge clk);
    rst = 0;
    send(8'h1C);
    drain("post_rst");
    chk("post_rst_ext", {31'd0, key_ext}, 0);

    // extended make/break and ext-mismatch break
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain("ext");
    send(8'hE0); send(8'h75); send(8'hF0); send(8'h75);
    drain("ext_mis");
    chk("ext_mis_held", {31'd0, key_held}, 1);
    chk("ext_mis_ext", {31'd0, key_ext}, 1);

    // F0 E0 order is also an extended break
    send(8'hF0); send(8'hE0); send(8'h75);
    drain("f0e0");
    chk("f0e0_held", {31'd0, key_held}, 0);

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C);
    drain("rep");

    // different key replaces held key; stale break ignored
    send(8'h2A); send(8'h3B); send(8'hF0); send(8'h2A);
    drain("replace");
    chk("replace_code", {24'd0, key_code}, 32'h3B);
    chk("replace_held", {31'd0, key_held}, 1);

    // counter wrap with back-to-back bytes, also checks pop spacing
    do_reset();
    gap_en = 1;
    for (int i = 0; i < 256; i++) begin
      send(8'h23); send(8'hF0); send(8'h23);
    end
    drain("wrap");
    gap_en = 0;
    chk("wrap_cnt", {24'd0, press_count}, 0);
    chk("err_before", {31'd0, proto_err}, 0);
    send(8'hFF);
    drain("err");
    chk("err_set", {31'd0, proto_err}, 1);
    send(8'h1C);
    drain("err_hold");
    chk("err_sticky", {31'd0, proto_err}, 1);
    do_reset();
    chk("err_clr", {31'd0, proto_err}, 0);

    // lone prefix followed by a long wait
    send(8'hF0);
    drain("tmo_pre");
    repeat (TMO + 10) @(negedge clk);
`ifdef PS2_PREFIX_TIMEOUT_EN
    m_ext = 0; m_brk = 0;
`endif
    send(8'h1C);
    drain("tmo");
`ifdef PS2_PREFIX_TIMEOUT_EN
    chk("tmo_held", {31'd0, key_held}, 1);
`else
    chk("tmo_held", {31'd0, key_held}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
